// File: rtl/mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_slot_arbiter
// Purpose  : Time-division arbiter for the single-port 64 KiB system RAM.
//            A free-running phase counter produces the CPU clock enable and
//            the video enable. Each requester owns one fixed RAM slot per
//            phase period. The loader takes over CPU slots and stalls the CPU
//            through CPU_READY.
// Ports    : CLK/nRESET         clock, synchronous active-low reset
//            CPU_*              MOS6502 side (enable, READY, bus, read data)
//            VID_*              video fetch side (enable, address, data, strobe)
//            LD_*               loader write port (level request, ack strobe)
//            RAM_*              registered RAM command, 1-cycle-latency rdata
// Revision : 1.0  initial release
// ============================================================================
module mem_slot_arbiter #(
  parameter int SLOT_BITS = 4,
  parameter int CPU_SLOT  = 15,
  parameter int VID_SLOT  = 7,
  parameter int ADDR_W    = 16
) (
  input  logic              CLK,
  input  logic              nRESET,
  output logic              CPU_en,
  output logic              CPU_READY,
  input  logic [ADDR_W-1:0] CPU_addr,
  input  logic              CPU_RnW,
  input  logic [7:0]        CPU_wdata,
  output logic [7:0]        CPU_rdata,
  output logic              VID_en,
  input  logic [ADDR_W-1:0] VID_addr,
  output logic [7:0]        VID_rdata,
  output logic              VID_valid,
  input  logic              LD_req,
  input  logic [ADDR_W-1:0] LD_addr,
  input  logic [7:0]        LD_wdata,
  output logic              LD_ack,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic              RAM_we,
  output logic [7:0]        RAM_wdata,
  input  logic [7:0]        RAM_rdata
);

  // Window phases for a slot S: decide at S-3, issue at S-2, capture at S-1.
  // Casting to SLOT_BITS wraps the subtraction modulo the period length.
  // The CPU and video windows must be at least 4 phases apart so that they
  // never share an issue or capture cycle.
  localparam logic [SLOT_BITS-1:0] c_cpu_slot = SLOT_BITS'(CPU_SLOT);
  localparam logic [SLOT_BITS-1:0] c_cpu_dec  = SLOT_BITS'(CPU_SLOT - 3);
  localparam logic [SLOT_BITS-1:0] c_cpu_cap  = SLOT_BITS'(CPU_SLOT - 1);
  localparam logic [SLOT_BITS-1:0] c_vid_slot = SLOT_BITS'(VID_SLOT);
  localparam logic [SLOT_BITS-1:0] c_vid_dec  = SLOT_BITS'(VID_SLOT - 3);
  localparam logic [SLOT_BITS-1:0] c_vid_cap  = SLOT_BITS'(VID_SLOT - 1);
  localparam logic [SLOT_BITS-1:0] c_ph_one   = SLOT_BITS'(1);

  logic [SLOT_BITS-1:0] ph_q,          ph_d;
  logic [ADDR_W-1:0]    ram_addr_q,    ram_addr_d;
  logic                 ram_we_q,      ram_we_d;
  logic [7:0]           ram_wdata_q,   ram_wdata_d;
  logic                 ld_ack_q,      ld_ack_d;
  logic                 cpu_ready_q,   cpu_ready_d;
  logic                 cpu_rd_pend_q, cpu_rd_pend_d;
  logic [7:0]           cpu_rdata_q,   cpu_rdata_d;
  logic [7:0]           vid_rdata_q,   vid_rdata_d;
  logic                 vid_valid_q,   vid_valid_d;

  always_comb begin
    ph_d          = ph_q + c_ph_one;
    ram_addr_d    = ram_addr_q;
    ram_we_d      = 1'b0;
    ram_wdata_d   = ram_wdata_q;
    ld_ack_d      = 1'b0;
    cpu_ready_d   = cpu_ready_q;
    cpu_rd_pend_d = cpu_rd_pend_q;
    cpu_rdata_d   = cpu_rdata_q;
    vid_rdata_d   = vid_rdata_q;
    vid_valid_d   = 1'b0;

    // Video decision: always a read, never displaced by the loader.
    if (ph_q == c_vid_dec) begin
      ram_addr_d = VID_addr;
    end

    // CPU decision: the loader steals the slot and stalls the CPU. READY is
    // only updated here, so it is stable across the whole CPU window.
    if (ph_q == c_cpu_dec) begin
      cpu_rd_pend_d = 1'b0;
      if (LD_req) begin
        ram_addr_d  = LD_addr;
        ram_we_d    = 1'b1;
        ram_wdata_d = LD_wdata;
        ld_ack_d    = 1'b1;
        cpu_ready_d = 1'b0;
      end else if (CPU_RnW) begin
        ram_addr_d    = CPU_addr;
        cpu_ready_d   = 1'b1;
        cpu_rd_pend_d = 1'b1;
      end else begin
        ram_addr_d  = CPU_addr;
        ram_we_d    = 1'b1;
        ram_wdata_d = CPU_wdata;
        cpu_ready_d = 1'b1;
      end
    end

    // Capture: RAM_rdata belongs to the command issued one cycle earlier.
    if ((ph_q == c_cpu_cap) && cpu_rd_pend_q) begin
      cpu_rdata_d   = RAM_rdata;
      cpu_rd_pend_d = 1'b0;
    end

    if (ph_q == c_vid_cap) begin
      vid_rdata_d = RAM_rdata;
      vid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      ph_q          <= '0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      ld_ack_q      <= 1'b0;
      cpu_ready_q   <= 1'b1;
      cpu_rd_pend_q <= 1'b0;
      cpu_rdata_q   <= '0;
      vid_rdata_q   <= '0;
      vid_valid_q   <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      ld_ack_q      <= ld_ack_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_rd_pend_q <= cpu_rd_pend_d;
      cpu_rdata_q   <= cpu_rdata_d;
      vid_rdata_q   <= vid_rdata_d;
      vid_valid_q   <= vid_valid_d;
    end
  end

  // Enables are decoded from the phase and held low while in reset.
  assign CPU_en    = nRESET & (ph_q == c_cpu_slot);
  assign VID_en    = nRESET & (ph_q == c_vid_slot);
  assign CPU_READY = cpu_ready_q;
  assign CPU_rdata = cpu_rdata_q;
  assign VID_rdata = vid_rdata_q;
  assign VID_valid = vid_valid_q;
  assign LD_ack    = ld_ack_q;
  assign RAM_addr  = ram_addr_q;
  assign RAM_we    = ram_we_q;
  assign RAM_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: doc/mem_slot_arbiter.md
Name: mem_slot_arbiter

Overview:
Time-division arbiter that shares the single-port 64 KiB system RAM between the MOS6502 core, the video fetch path and a loader/debug write port. A free-running phase counter generates the CPU clock enable (CLK_en) and the video enable, and gives each requester a fixed RAM slot per phase period. The CPU's data is always ready before it samples on its enable edge. The loader steals CPU slots and stalls the CPU through READY.

Parameters:
SLOT_BITS, 4, phase counter width; one period is 2^SLOT_BITS CLK cycles
CPU_SLOT, 15, phase value at which CPU_en is high
VID_SLOT, 7, phase value at which VID_en and VID_valid are high
ADDR_W, 16, RAM address width

Ports:
CLK  in  1  system clock, all logic on rising edge
nRESET  in  1  synchronous active-low reset
CPU_en  out  1  CPU clock enable (drives MOS6502 CLK_en)
CPU_READY  out  1  drives MOS6502 READY; low while loader owns the CPU slot
CPU_addr  in  ADDR_W  CPU address bus
CPU_RnW  in  1  CPU read(1)/write(0)
CPU_wdata  in  8  CPU write data
CPU_rdata  out  8  registered read data to CPU Data_bus
VID_en  out  1  video clock enable
VID_addr  in  ADDR_W  video fetch address
VID_rdata  out  8  registered video read data
VID_valid  out  1  one-cycle strobe, VID_rdata updated
LD_req  in  1  loader write request (level)
LD_addr  in  ADDR_W  loader write address
LD_wdata  in  8  loader write data
LD_ack  out  1  one-cycle strobe, loader write issued
RAM_addr  out  ADDR_W  RAM address (registered)
RAM_we  out  1  RAM write enable (registered)
RAM_wdata  out  8  RAM write data (registered)
RAM_rdata  in  8  synchronous RAM read data, 1-cycle latency

Behaviour:
- ph: SLOT_BITS counter that increments every CLK and wraps from 2^SLOT_BITS-1 to 0.
- CPU_en = (ph==CPU_SLOT). VID_en = (ph==VID_SLOT). Both are decoded from ph and forced to 0 while nRESET is low.
- Slot window for slot S (all arithmetic mod 2^SLOT_BITS):
  - Decision edge: end of cycle S-3.
  - Issue cycle S-2: RAM_addr/RAM_we/RAM_wdata are valid.
  - Cycle S-1: RAM_rdata is valid; the target read register captures it at the end of S-1.
  - Cycle S: the data is visible to the requester.
- Slot placement: CPU_SLOT and VID_SLOT windows must not overlap, so the circular distance between them must be at least 4. With the defaults, CPU issues at ph=13 and video issues at ph=5.
- CPU decision (end of ph==CPU_SLOT-3):
  - If LD_req=1: issue RAM_addr=LD_addr, RAM_we=1, RAM_wdata=LD_wdata. LD_ack=1 for the issue cycle only. CPU_READY<=0. CPU_rdata holds.
  - Else if CPU_RnW=1: issue a read of CPU_addr with RAM_we=0. CPU_READY<=1. CPU_rdata<=RAM_rdata at the end of CPU_SLOT-1. CPU_rdata holds until the next CPU read capture.
  - Else (CPU write): RAM_addr=CPU_addr, RAM_we=1, RAM_wdata=CPU_wdata. CPU_READY<=1. CPU_rdata holds.
- CPU_READY changes only at CPU decision edges, so it is stable for the whole CPU window. The CPU core holds its state on any CPU_en with READY low, for both reads and writes.
- Video decision (end of ph==VID_SLOT-3): always a read of VID_addr with RAM_we=0. VID_rdata<=RAM_rdata at the end of VID_SLOT-1. VID_valid=1 during ph==VID_SLOT only.
- Video never stalls and is never displaced by the loader.
- Non-issue cycles: RAM_we=0. RAM_addr and RAM_wdata hold their last values.
- RAM_we is never high for more than one consecutive cycle.
- LD_req dropped before a decision edge: no write is issued, and LD_ack stays 0.
- LD_req held high: the loader gets one write per period, and the CPU stays stalled.
- Reset (any cycle, including mid-window), state after the edge with nRESET=0:
  - ph=0.
  - RAM_we=0, RAM_addr=0, RAM_wdata=0.
  - CPU_rdata=0, VID_rdata=0.
  - VID_valid=0, LD_ack=0, CPU_READY=1.
  - An in-flight write is dropped; no RAM_we pulse occurs after a reset edge.
- First cycle with nRESET high has ph=0.

Test Plan:
1. Release reset and run 48 CLKs, defaults -> CPU_en high only in cycles 15, 31, 47 after release; VID_en only in cycles 7, 23, 39; RAM_we stays 0 with no requests.
2. RAM[0x1234]=0xAB, CPU_addr=0x1234, CPU_RnW=1 -> RAM_addr=0x1234 during ph=13; CPU_rdata=0xAB from ph=15 until the next CPU capture; CPU_READY=1.
3. CPU write, CPU_addr=0x0200, CPU_wdata=0x55, CPU_RnW=0 -> RAM_we=1 for exactly the ph=13 cycle with RAM_addr=0x0200, RAM_wdata=0x55; CPU_rdata unchanged.
4. RAM[0x7C00]=0x3F, VID_addr=0x7C00, simultaneous CPU read of 0x1234 -> RAM_addr=0x7C00 at ph=5 and 0x1234 at ph=13; VID_valid single pulse at ph=7 with VID_rdata=0x3F; CPU_rdata=0xAB at ph=15.
5. LD_req=1 at ph=12 with LD_addr=0x0300, LD_wdata=0x99 for one period, then LD_req=0 -> RAM_we and LD_ack high at ph=13 with RAM[0x0300]=0x99; CPU_READY=0 from ph=13 until the next ph=13, then 1; CPU's pending read issued one period later.
6. Assert nRESET=0 during ph=13 of a CPU write -> next cycle RAM_we=0, ph=0, CPU_READY=1, CPU_rdata=0; RAM location unchanged if the reset edge preceded the issue edge.
